// File: rtl/metronome_pkg.sv
// Shared types and constants for the metronome tempo path.
// BPM bounds, the button command set, the FSM states and the clamped BPM update.
package metronome_pkg;

   localparam int unsigned BPM_W       = 8;
   localparam int unsigned BPM_MIN     = 30;
   localparam int unsigned BPM_MAX     = 240;
   localparam int unsigned BPM_DEFAULT = 120;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_RST,
      CMD_P1,
      CMD_P5,
      CMD_M1,
      CMD_M5
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      DONE
   } state_e;

   // One extra bit keeps 238+5 from wrapping before the clamp; minus floors at zero first.
   function automatic logic [BPM_W-1:0] bpm_adjust(input cmd_e             cmd,
                                                   input logic [BPM_W-1:0] bpm,
                                                   input logic [BPM_W-1:0] lo,
                                                   input logic [BPM_W-1:0] hi);
      logic [BPM_W:0] sum;
      sum = {1'b0, bpm};
      case (cmd)
         CMD_P1:  sum = sum + (BPM_W+1)'(1);
         CMD_P5:  sum = sum + (BPM_W+1)'(5);
         CMD_M1:  sum = (sum < (BPM_W+1)'(1)) ? '0 : sum - (BPM_W+1)'(1);
         CMD_M5:  sum = (sum < (BPM_W+1)'(5)) ? '0 : sum - (BPM_W+1)'(5);
         default: ;
      endcase
      if (sum > {1'b0, hi}) begin
         return hi;
      end else if (sum < {1'b0, lo}) begin
         return lo;
      end
      return sum[BPM_W-1:0];
   endfunction

endpackage

// File: rtl/metronome_tempo_ctrl_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// The start cycle performs the first iteration, so done pulses W cycles after start.
module tempo_divider #(
   parameter int unsigned W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_divisor,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_quotient
);

   localparam int unsigned CNT_W = $clog2(W);

   logic [W-1:0]     rem_q, rem_d;
   logic [W-1:0]     quo_q, quo_d;
   logic [W-1:0]     div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [W-1:0]     rem_src, quo_src, div_src;
   logic [W:0]       shifted;
   logic [W-1:0]     rem_step, quo_step;

   // Reasserting start mid-division simply reloads the operands: that is the abort.
   always_comb begin
      rem_src  = i_start ? '0         : rem_q;
      quo_src  = i_start ? i_dividend : quo_q;
      div_src  = i_start ? i_divisor  : div_q;
      shifted  = {rem_src, quo_src[W-1]};
      if (shifted >= {1'b0, div_src}) begin
         rem_step = W'(shifted - {1'b0, div_src});
         quo_step = {quo_src[W-2:0], 1'b1};
      end else begin
         rem_step = shifted[W-1:0];
         quo_step = {quo_src[W-2:0], 1'b0};
      end
   end

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (i_start) begin
         rem_d  = rem_step;
         quo_d  = quo_step;
         div_d  = i_divisor;
         cnt_d  = CNT_W'(1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = rem_step;
         quo_d = quo_step;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(W - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_quotient = quo_q;

endmodule

// File: rtl/metronome_tempo_ctrl.sv
// Tempo controller: arbitrates button pulses, holds the clamped BPM, recomputes the
// beat period with an iterative divider and emits a beat tick every period.
module metronome_tempo_ctrl
   import metronome_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned BPM_MIN     = metronome_pkg::BPM_MIN,
   parameter int unsigned BPM_MAX     = metronome_pkg::BPM_MAX,
   parameter int unsigned BPM_DEFAULT = metronome_pkg::BPM_DEFAULT,
   parameter int unsigned PERIOD_W    = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_btn_reset,
   input  logic                i_btn_plus_1,
   input  logic                i_btn_plus_5,
   input  logic                i_btn_minus_1,
   input  logic                i_btn_minus_5,
   output logic [BPM_W-1:0]    o_bpm,
   output logic [PERIOD_W-1:0] o_period,
   output logic                o_period_valid,
   output logic                o_busy,
   output logic                o_beat
);

   // CLK_HZ*60 overflows a 32-bit int for the default clock, so widen first.
   localparam logic [63:0]         DIVIDEND_WIDE = 64'(CLK_HZ) * 64'd60;
   localparam logic [PERIOD_W-1:0] DIVIDEND      = PERIOD_W'(DIVIDEND_WIDE);
   localparam logic [PERIOD_W-1:0] RST_PERIOD    = PERIOD_W'(DIVIDEND_WIDE / 64'(BPM_DEFAULT));
   localparam logic [BPM_W-1:0]    BPM_LO        = BPM_W'(BPM_MIN);
   localparam logic [BPM_W-1:0]    BPM_HI        = BPM_W'(BPM_MAX);
   localparam logic [BPM_W-1:0]    BPM_RST       = BPM_W'(BPM_DEFAULT);

   state_e              state_q, state_d;
   logic [BPM_W-1:0]    bpm_q, bpm_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   cmd_e                pend_q, pend_d;
   logic [PERIOD_W-1:0] beat_cnt_q, beat_cnt_d;
   logic                beat_q, beat_d;

   cmd_e                btn_cmd;
   cmd_e                act;
   logic                div_start;
   logic                div_busy;
   logic                div_done;
   logic [PERIOD_W-1:0] div_quotient;

   // NOTE: every always_comb output gets a default first, otherwise a path that skips
   // an assignment infers a latch.
   always_comb begin
      btn_cmd = CMD_NONE;
      if      (i_btn_reset)   btn_cmd = CMD_RST;
      else if (i_btn_minus_5) btn_cmd = CMD_M5;
      else if (i_btn_minus_1) btn_cmd = CMD_M1;
      else if (i_btn_plus_5)  btn_cmd = CMD_P5;
      else if (i_btn_plus_1)  btn_cmd = CMD_P1;
   end

   always_comb begin
      state_d   = state_q;
      bpm_d     = bpm_q;
      period_d  = period_q;
      pend_d    = pend_q;
      act       = CMD_NONE;
      div_start = 1'b0;
      if (btn_cmd == CMD_RST) begin
         bpm_d     = BPM_RST;
         pend_d    = CMD_NONE;
         div_start = 1'b1;
         state_d   = DIVIDE;
      end else begin
         case (state_q)
            IDLE: begin
               act = btn_cmd;
               // A parked command goes first; a fresh pulse this cycle takes its slot.
               if (pend_q != CMD_NONE) begin
                  act    = pend_q;
                  pend_d = btn_cmd;
               end
               if (act != CMD_NONE) begin
                  bpm_d     = bpm_adjust(act, bpm_q, BPM_LO, BPM_HI);
                  div_start = 1'b1;
                  state_d   = DIVIDE;
               end
            end
            DIVIDE: begin
               if (pend_q == CMD_NONE) pend_d = btn_cmd;
               if (div_done) begin
                  period_d = div_quotient;
                  state_d  = DONE;
               end
            end
            DONE: begin
               if (pend_q == CMD_NONE) pend_d = btn_cmd;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // The running beat finishes on the old period; the new one loads at the boundary.
   always_comb begin
      beat_d     = 1'b0;
      beat_cnt_d = beat_cnt_q - PERIOD_W'(1);
      if (beat_cnt_q == '0) begin
         beat_d     = 1'b1;
         beat_cnt_d = period_q - PERIOD_W'(1);
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         bpm_q      <= BPM_RST;
         period_q   <= RST_PERIOD;
         pend_q     <= CMD_NONE;
         beat_cnt_q <= RST_PERIOD - PERIOD_W'(1);
         beat_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bpm_q      <= bpm_d;
         period_q   <= period_d;
         pend_q     <= pend_d;
         beat_cnt_q <= beat_cnt_d;
         beat_q     <= beat_d;
      end
   end

   tempo_divider #(
      .W (PERIOD_W)
   ) u_divider (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (div_start),
      .i_dividend (DIVIDEND),
      .i_divisor  (PERIOD_W'(bpm_d)),
      .o_busy     (div_busy),
      .o_done     (div_done),
      .o_quotient (div_quotient)
   );

   assign o_bpm          = bpm_q;
   assign o_period       = period_q;
   assign o_period_valid = (state_q == DONE);
   assign o_busy         = div_busy | (state_q != IDLE);
   assign o_beat         = beat_q;

endmodule

// File: doc/metronome_tempo_ctrl.md
# metronome_tempo_ctrl

Tempo controller for the metronome. It consumes the single-cycle button pulses from the button debouncer: reset, +1, +5, −1 and −5. It holds the current BPM with saturating arithmetic and computes the beat period in clock ticks using an iterative divider. It also generates the beat tick that drives the click and display path downstream.

## Interface
Parameters:
- CLK_HZ, 50_000_000: input clock frequency in Hz.
- BPM_MIN, 30: lower BPM bound, inclusive.
- BPM_MAX, 240: upper BPM bound, inclusive.
- BPM_DEFAULT, 120: BPM value after reset.
- PERIOD_W, 32: width of the period and of the divider datapath.

Ports:
- Clock and reset: one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
- i_clk, in, 1: sole clock.
- i_rst_n, in, 1: async active-low reset.
- i_btn_reset, in, 1: pulse, restore BPM_DEFAULT.
- i_btn_plus_1, in, 1: pulse, BPM +1.
- i_btn_plus_5, in, 1: pulse, BPM +5.
- i_btn_minus_1, in, 1: pulse, BPM −1.
- i_btn_minus_5, in, 1: pulse, BPM −5.
- o_bpm, out, 8: current BPM.
- o_period, out, PERIOD_W: beat period in ticks, CLK_HZ*60/o_bpm, truncated.
- o_period_valid, out, 1: one-cycle strobe when o_period updates.
- o_busy, out, 1: high while a division is in progress.
- o_beat, out, 1: one-cycle beat tick.

## Operation
- FSM states: IDLE, DIVIDE, DONE.
- Command arbitration (same-cycle pulses): btn_reset > minus_5 > minus_1 > plus_5 > plus_1. Lower-priority pulses in that cycle are discarded.
- Arithmetic on BPM is done in 9 bits and clamped to [BPM_MIN, BPM_MAX]. Examples: 238+5 gives 240; 32−5 gives 30; 240+1 gives 240.
- IDLE + adjust command:
  - o_bpm is updated at that edge.
  - The divider starts with dividend CLK_HZ*60 and divisor equal to the new BPM.
  - The FSM moves to DIVIDE.
- A saturated no-change command, such as +1 at BPM_MAX, still triggers a recompute.
- DIVIDE is a restoring division, one quotient bit per cycle, PERIOD_W iterations, then DONE.
- DONE: o_period is loaded with the quotient, o_period_valid pulses, and the FSM returns to IDLE.
- Adjust pulses during DIVIDE or DONE go to a one-deep pending slot:
  - The first captured command is kept; later adjusts are dropped.
  - The pending command is applied in the first IDLE cycle, as if freshly received.
- btn_reset in any state:
  - o_bpm is set to BPM_DEFAULT and the pending slot is cleared.
  - Any ongoing division is aborted and restarted (iteration counter = 0).
- Beat generator:
  - A down-counter is loaded with o_period−1.
  - When it reaches 0, o_beat pulses and the counter reloads from the o_period value current at that moment.
  - A new period therefore takes effect at the next beat boundary; the current beat is never truncated.

## Timing
- Reset values:
  - o_bpm = BPM_DEFAULT.
  - o_period = CLK_HZ*60/BPM_DEFAULT, an elaboration-time constant.
  - o_period_valid = 0, o_busy = 0, o_beat = 0.
  - Beat counter = o_period−1; FSM = IDLE; pending slot empty.
- The first o_beat occurs exactly o_period cycles after reset deassertion, and every o_period cycles thereafter.
- Command latency:
  - A pulse in cycle N (IDLE) makes o_bpm valid in N+1 and o_busy high in N+1..N+PERIOD_W+1.
  - o_period_valid is high in cycle N+PERIOD_W+1 with the new o_period.
- A pending command starts in the cycle after DONE, with the same latency.
- btn_reset restart: its o_period_valid arrives PERIOD_W+1 cycles after the reset pulse, regardless of prior state.
- o_period is stable except in the single update cycle; o_bpm changes only at command acceptance.

## Structure
- Shared package metronome_pkg holds:
  - BPM_MIN, BPM_MAX, BPM_DEFAULT and BPM_W = 8.
  - The command enum {CMD_NONE, CMD_RST, CMD_P1, CMD_P5, CMD_M1, CMD_M5}.
  - The FSM state typedef.
- Sub-module tempo_divider is an iterative restoring unsigned divider.
  - Interface: start, dividend, divisor, busy, done, quotient.
  - Abort is done by reasserting start.
- The top level contains the arbiter, the saturating adder, the pending slot, the FSM and the beat counter.

## Test plan
All scenarios use CLK_HZ=1000 and PERIOD_W=32.
- Reset, no buttons → o_bpm=120, o_period=500; o_beat at cycles 500, 1000, 1500 after reset release.
- plus_5 pulse → o_bpm=125 next cycle; o_period_valid exactly 33 cycles after the pulse, with o_period=480; the in-flight beat still completes at 500 before the 480 spacing starts.
- Saturation:
  - From 120, 30× plus_5 → o_bpm=240, o_period=250.
  - From 30, minus_1 → o_bpm stays 30, o_period=2000, with a recompute strobe.
- Same-cycle plus_1 and minus_5 at 120 → o_bpm=115 only; a single o_period_valid with o_period=521.
- Pulses during busy:
  - minus_1 at cycle 5 of a division, then plus_1 at cycle 6 → only minus_1 is applied after DONE.
  - btn_reset mid-divide → o_bpm=120, the division restarts, and o_period_valid arrives 33 cycles after the reset pulse with o_period=500.
- i_rst_n asserted mid-divide → all outputs at reset values immediately (async), and normal beats resume after release.
